// File: rtl/l2_mstream_pkg.sv
// Shared types and helpers for the multi-stream L2 pointer block.
// Default geometry, the per-stream context struct and the window clamp.
package l2_mstream_pkg;

    function automatic int unsigned cnt_width(input int unsigned ncl);
        return $clog2(ncl + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n);
    endfunction

    localparam int unsigned ADDR_WIDTH = 64;
    localparam int unsigned CACHE_LINE = 128;
    localparam int unsigned L2_NCL     = 256;
    localparam int unsigned NSTRM      = 4;
    localparam int unsigned CLW        = idx_width(CACHE_LINE);
    localparam int unsigned NCL_W      = idx_width(L2_NCL);
    localparam int unsigned SID_W      = idx_width(NSTRM);
    localparam int unsigned CNT_W      = cnt_width(L2_NCL);

    typedef struct packed {
        logic                  act;
        logic [ADDR_WIDTH-1:0] ea;
        logic [ADDR_WIDTH-1:0] ea_e;
        logic [NCL_W-1:0]      clid;
        logic [CNT_W-1:0]      nval;
        logic [CNT_W-1:0]      nout;
        logic [CNT_W-1:0]      win;
    } strm_ctx_t;

    // A zero or oversized window means "use the whole per-stream L2 area".
    function automatic logic [CNT_W-1:0] win_clamp(input logic [CNT_W-1:0] w);
        if (w == '0 || w > CNT_W'(L2_NCL)) begin
            return CNT_W'(L2_NCL);
        end
        return w;
    endfunction

endpackage

// File: rtl/l2_mstream_rr_arb.sv
// Round-robin arbiter: grant held while the winner waits, pointer advances past
// the winner on accept.
module l2_mstream_rr_arb #(
    parameter int unsigned n     = 4,
    parameter int unsigned sid_w = $clog2(n)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [n-1:0]     req,
    input  logic             ack,
    output logic             gnt_v_c,
    output logic [sid_w-1:0] gnt_sid_c
);

    logic [sid_w-1:0] ptr;
    logic [sid_w-1:0] lock_sid;
    logic [sid_w-1:0] pick;
    logic [sid_w-1:0] idx;
    logic             lock;
    logic             found;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < n; i++) begin
            idx = ptr + sid_w'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // A stalled winner stays eligible, so replaying its sid is always safe.
    assign gnt_v_c   = |req;
    assign gnt_sid_c = lock ? lock_sid : pick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            lock     <= 1'b0;
            lock_sid <= '0;
        end else begin
            lock     <= gnt_v_c & ~ack;
            lock_sid <= gnt_sid_c;
            if (ack) begin
                ptr <= gnt_sid_c + sid_w'(1);
            end
        end
    end

endmodule

// File: rtl/l2_mstream_ptr.sv
// Multi-stream L2 pointer: per-stream EA/clid/counter contexts, round-robin host
// request issue and a registered URAM read-address port.
module l2_mstream_ptr
    import l2_mstream_pkg::*;
#(
    parameter int unsigned addr_width = ADDR_WIDTH,
    parameter int unsigned cache_line = CACHE_LINE,
    parameter int unsigned l2_ncl     = L2_NCL,
    parameter int unsigned nstrm      = NSTRM,
    parameter int unsigned clw        = idx_width(cache_line),
    parameter int unsigned ncl_w      = idx_width(l2_ncl),
    parameter int unsigned sid_w      = idx_width(nstrm),
    parameter int unsigned cnt_w      = cnt_width(l2_ncl)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_rst_v,
    output logic                   i_rst_r,
    input  logic [sid_w-1:0]       i_rst_sid,
    input  logic [addr_width-1:0]  i_rst_ea_b,
    input  logic [addr_width-1:0]  i_rst_ea_e,
    input  logic [cnt_w-1:0]       i_rst_win,
    input  logic                   i_rd_v,
    output logic                   i_rd_r,
    input  logic [sid_w-1:0]       i_rd_sid,
    output logic                   o_addr_v,
    input  logic                   o_addr_r,
    output logic [sid_w+ncl_w-1:0] o_addr_ptr,
    output logic                   o_req_v,
    input  logic                   o_req_r,
    output logic [addr_width-1:0]  o_req_ea,
    output logic [sid_w-1:0]       o_req_sid,
    input  logic                   i_rsp_v,
    input  logic [sid_w-1:0]       i_rsp_sid,
    output logic                   i_rsp_r,
    output logic [nstrm-1:0]       o_end
);

    strm_ctx_t        ctx [nstrm];
    logic [nstrm-1:0] idle;
    logic [nstrm-1:0] elig;
    logic [nstrm-1:0] rst_hit;
    logic [nstrm-1:0] req_hit;
    logic [nstrm-1:0] rsp_hit;
    logic [nstrm-1:0] rd_hit;
    logic             rst_acc;
    logic             req_acc;
    logic             rd_acc;
    logic             arb_v;
    logic [sid_w-1:0] gnt;

    // Stream status; the sum is widened so a full window cannot wrap.
    always_comb begin
        idle = '0;
        elig = '0;
        for (int s = 0; s < nstrm; s++) begin
            idle[s] = ctx[s].act && (ctx[s].ea >= ctx[s].ea_e)
                      && (ctx[s].nout == '0) && (ctx[s].nval == '0);
            elig[s] = ctx[s].act && (ctx[s].ea < ctx[s].ea_e)
                      && (({1'b0, ctx[s].nval} + {1'b0, ctx[s].nout}) < {1'b0, ctx[s].win});
        end
    end

    l2_mstream_rr_arb #(
        .n     (nstrm),
        .sid_w (sid_w)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (elig),
        .ack       (req_acc),
        .gnt_v_c   (arb_v),
        .gnt_sid_c (gnt)
    );

    assign i_rst_r   = ~ctx[i_rst_sid].act | idle[i_rst_sid];
    assign rst_acc   = i_rst_v & i_rst_r;
    assign i_rd_r    = ctx[i_rd_sid].act & (ctx[i_rd_sid].nval != '0) & (~o_addr_v | o_addr_r);
    assign rd_acc    = i_rd_v & i_rd_r;
    assign o_req_v   = arb_v;
    assign req_acc   = arb_v & o_req_r;
    assign o_req_sid = arb_v ? gnt : '0;
    assign o_req_ea  = arb_v ? ctx[gnt].ea : '0;
    assign i_rsp_r   = 1'b1;

    always_comb begin
        rst_hit = '0;
        req_hit = '0;
        rsp_hit = '0;
        rd_hit  = '0;
        rst_hit[i_rst_sid] = rst_acc;
        req_hit[gnt]       = req_acc;
        rsp_hit[i_rsp_sid] = i_rsp_v;
        rd_hit[i_rd_sid]   = rd_acc;
    end

    // Reset only lands on an inactive or idle stream, so it never races other updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < nstrm; s++) begin
                ctx[s] <= '0;
            end
        end else begin
            for (int s = 0; s < nstrm; s++) begin
                if (rst_hit[s]) begin
                    ctx[s].act  <= 1'b1;
                    ctx[s].ea   <= {i_rst_ea_b[addr_width-1:clw], clw'(0)};
                    ctx[s].ea_e <= i_rst_ea_e;
                    ctx[s].clid <= i_rst_ea_b[ncl_w+clw-1:clw];
                    ctx[s].nval <= '0;
                    ctx[s].nout <= '0;
                    ctx[s].win  <= win_clamp(i_rst_win);
                end else begin
                    if (req_hit[s]) begin
                        ctx[s].ea <= ctx[s].ea + addr_width'(cache_line);
                    end
                    if (rd_hit[s]) begin
                        ctx[s].clid <= ctx[s].clid + ncl_w'(1);
                    end
                    ctx[s].nout <= ctx[s].nout + cnt_w'(req_hit[s]) - cnt_w'(rsp_hit[s]);
                    ctx[s].nval <= ctx[s].nval + cnt_w'(rsp_hit[s]) - cnt_w'(rd_hit[s]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_addr_v   <= 1'b0;
            o_addr_ptr <= '0;
            o_end      <= '0;
        end else begin
            if (rd_acc) begin
                o_addr_v   <= 1'b1;
                o_addr_ptr <= {i_rd_sid, ctx[i_rd_sid].clid};
            end else if (o_addr_r) begin
                o_addr_v <= 1'b0;
            end
            o_end <= idle;
        end
    end

endmodule

// File: tb/tb_l2_mstream_ptr.sv
// Bench for l2_mstream_ptr: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a per-stream behavioural model.
module tb_l2_mstream_ptr;

    localparam int NS  = 4;
    localparam int NCL = 256;
    localparam int CL  = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_rst_v;
    logic        i_rst_r;
    logic [1:0]  i_rst_sid;
    logic [63:0] i_rst_ea_b;
    logic [63:0] i_rst_ea_e;
    logic [8:0]  i_rst_win;
    logic        i_rd_v;
    logic        i_rd_r;
    logic [1:0]  i_rd_sid;
    logic        o_addr_v;
    logic        o_addr_r;
    logic [9:0]  o_addr_ptr;
    logic        o_req_v;
    logic        o_req_r;
    logic [63:0] o_req_ea;
    logic [1:0]  o_req_sid;
    logic        i_rsp_v;
    logic [1:0]  i_rsp_sid;
    logic        i_rsp_r;
    logic [3:0]  o_end;

    always #5 clk = ~clk;

    l2_mstream_ptr dut (
        .clk        (clk),
        .reset      (reset),
        .i_rst_v    (i_rst_v),
        .i_rst_r    (i_rst_r),
        .i_rst_sid  (i_rst_sid),
        .i_rst_ea_b (i_rst_ea_b),
        .i_rst_ea_e (i_rst_ea_e),
        .i_rst_win  (i_rst_win),
        .i_rd_v     (i_rd_v),
        .i_rd_r     (i_rd_r),
        .i_rd_sid   (i_rd_sid),
        .o_addr_v   (o_addr_v),
        .o_addr_r   (o_addr_r),
        .o_addr_ptr (o_addr_ptr),
        .o_req_v    (o_req_v),
        .o_req_r    (o_req_r),
        .o_req_ea   (o_req_ea),
        .o_req_sid  (o_req_sid),
        .i_rsp_v    (i_rsp_v),
        .i_rsp_sid  (i_rsp_sid),
        .i_rsp_r    (i_rsp_r),
        .o_end      (o_end)
    );

    // Behavioural model: one record per stream, plain integers.
    bit              m_act  [NS];
    longint unsigned m_ea   [NS];
    longint unsigned m_ea_e [NS];
    int              m_clid [NS];
    int              m_nval [NS];
    int              m_nout [NS];
    int              m_win  [NS];
    int              m_last_next;
    bit              m_hold;
    int              m_hold_sid;
    bit              m_addr_v;
    int              m_addr_ptr;
    bit [NS-1:0]     m_end;

    int              n_chk  = 0;
    int              n_pass = 0;
    longint unsigned acc_ea [$];
    int              acc_sid[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    endtask

    function automatic bit m_idle(input int s);
        return m_act[s] && m_ea[s] >= m_ea_e[s] && m_nout[s] == 0 && m_nval[s] == 0;
    endfunction

    function automatic bit m_elig(input int s);
        return m_act[s] && m_ea[s] < m_ea_e[s] && (m_nval[s] + m_nout[s]) < m_win[s];
    endfunction

    // Winner: a stalled offer is replayed, otherwise the next eligible sid in turn.
    function automatic int m_grant();
        if (m_hold && m_elig(m_hold_sid)) return m_hold_sid;
        for (int k = 0; k < NS; k++) begin
            if (m_elig((m_last_next + k) % NS)) return (m_last_next + k) % NS;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            m_act[s] = 0; m_ea[s] = 0; m_ea_e[s] = 0; m_clid[s] = 0;
            m_nval[s] = 0; m_nout[s] = 0; m_win[s] = 0;
        end
        m_last_next = 0; m_hold = 0; m_hold_sid = 0;
        m_addr_v = 0; m_addr_ptr = 0; m_end = '0;
    endtask

    task automatic idle_inputs();
        i_rst_v = 0; i_rst_sid = 0; i_rst_ea_b = 0; i_rst_ea_e = 0; i_rst_win = 0;
        i_rd_v = 0; i_rd_sid = 0; o_addr_r = 1; o_req_r = 0; i_rsp_v = 0; i_rsp_sid = 0;
    endtask

    task automatic compare_all();
        int g;
        g = m_grant();
        chk("o_req_v", o_req_v, 64'(g >= 0));
        if (g >= 0) begin
            chk("o_req_sid", o_req_sid, 64'(g));
            chk("o_req_ea", o_req_ea, m_ea[g]);
        end
        chk("i_rst_r", i_rst_r, 64'(!m_act[i_rst_sid] || m_idle(i_rst_sid)));
        chk("i_rd_r", i_rd_r, 64'(m_act[i_rd_sid] && m_nval[i_rd_sid] != 0 && (!m_addr_v || o_addr_r)));
        chk("o_addr_v", o_addr_v, 64'(m_addr_v));
        if (m_addr_v) chk("o_addr_ptr", o_addr_ptr, 64'(m_addr_ptr));
        chk("o_end", o_end, 64'(m_end));
        chk("i_rsp_r", i_rsp_r, 64'd1);
    endtask

    task automatic update_model();
        int          g;
        int          w;
        bit          ra;
        bit          qa;
        bit          da;
        bit [NS-1:0] idl;
        g  = m_grant();
        ra = i_rst_v && (!m_act[i_rst_sid] || m_idle(i_rst_sid));
        qa = (g >= 0) && o_req_r;
        da = i_rd_v && m_act[i_rd_sid] && m_nval[i_rd_sid] != 0 && (!m_addr_v || o_addr_r);
        for (int s = 0; s < NS; s++) idl[s] = m_idle(s);
        m_end = idl;
        if (da) begin
            m_addr_v   = 1;
            m_addr_ptr = int'(i_rd_sid) * NCL + m_clid[i_rd_sid];
        end else if (o_addr_r) begin
            m_addr_v = 0;
        end
        m_hold = (g >= 0) && !o_req_r;
        if (m_hold) m_hold_sid = g;
        if (qa) begin
            m_last_next = (g + 1) % NS;
            m_ea[g]     = m_ea[g] + CL;
            m_nout[g]   = m_nout[g] + 1;
        end
        if (i_rsp_v) begin
            m_nout[i_rsp_sid] = m_nout[i_rsp_sid] - 1;
            m_nval[i_rsp_sid] = m_nval[i_rsp_sid] + 1;
        end
        if (da) begin
            m_nval[i_rd_sid] = m_nval[i_rd_sid] - 1;
            m_clid[i_rd_sid] = (m_clid[i_rd_sid] + 1) % NCL;
        end
        if (ra) begin
            w = int'(i_rst_win);
            m_act[i_rst_sid]  = 1;
            m_ea[i_rst_sid]   = i_rst_ea_b - (i_rst_ea_b % CL);
            m_ea_e[i_rst_sid] = i_rst_ea_e;
            m_clid[i_rst_sid] = int'((i_rst_ea_b / CL) % NCL);
            m_nval[i_rst_sid] = 0;
            m_nout[i_rst_sid] = 0;
            m_win[i_rst_sid]  = (w == 0 || w > NCL) ? NCL : w;
        end
    endtask

    // One clock: inputs were set at the preceding negedge.
    task automatic cycle();
        #1;
        compare_all();
        if (o_req_v && o_req_r) begin
            acc_ea.push_back(o_req_ea);
            acc_sid.push_back(int'(o_req_sid));
        end
        update_model();
        @(negedge clk);
    endtask

    task automatic hard_reset();
        reset = 1'b0;
        idle_inputs();
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load(input int sid, input longint unsigned b, input longint unsigned e, input int win);
        i_rst_v = 1; i_rst_sid = 2'(sid); i_rst_ea_b = b; i_rst_ea_e = e; i_rst_win = 9'(win);
        cycle();
        i_rst_v = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_clear();
        #3;
        chk("rst_o_req_v", o_req_v, 0);
        chk("rst_o_req_ea", o_req_ea, 0);
        chk("rst_o_addr_v", o_addr_v, 0);
        chk("rst_o_end", o_end, 0);
        chk("rst_i_rst_r", i_rst_r, 1);
        chk("rst_i_rsp_r", i_rsp_r, 1);
        @(negedge clk);
        reset = 1'b1;

        // Single stream, window 4: exactly four requests then stall.
        load(0, 64'h1000, 64'h1400, 4);
        o_req_r = 1; acc_ea.delete(); acc_sid.delete();
        repeat (8) cycle();
        chk("t1_nreq", 64'(acc_ea.size()), 4);
        for (int k = 0; k < acc_ea.size() && k < 4; k++)
            chk("t1_ea", acc_ea[k], 64'h1000 + 64'(k * CL));
        chk("t1_req_v_low", o_req_v, 0);

        // Round-robin alternation and hold under back-pressure.
        hard_reset();
        load(0, 64'h1000, 64'h2000, 8);
        load(1, 64'h9000, 64'hA000, 8);
        o_req_r = 1; acc_ea.delete(); acc_sid.delete();
        repeat (4) cycle();
        chk("t2_n", 64'(acc_sid.size()), 4);
        if (acc_sid.size() == 4) begin
            chk("t2_sid0", 64'(acc_sid[0]), 0); chk("t2_ea0", acc_ea[0], 64'h1000);
            chk("t2_sid1", 64'(acc_sid[1]), 1); chk("t2_ea1", acc_ea[1], 64'h9000);
            chk("t2_sid2", 64'(acc_sid[2]), 0); chk("t2_ea2", acc_ea[2], 64'h1080);
            chk("t2_sid3", 64'(acc_sid[3]), 1); chk("t2_ea3", acc_ea[3], 64'h9080);
        end
        o_req_r = 0;
        repeat (3) begin
            cycle();
            chk("t2_hold_sid", o_req_sid, 0);
            chk("t2_hold_ea", o_req_ea, 64'h1100);
        end

        // Read path with clid wrap, then end-of-stream and re-reset.
        hard_reset();
        load(0, 64'h7F80, 64'h8080, 4);
        o_req_r = 1; repeat (2) cycle(); o_req_r = 0;
        i_rsp_v = 1; i_rsp_sid = 0; repeat (2) cycle(); i_rsp_v = 0;
        i_rst_sid = 0;
        #1 chk("t3_rst_r_busy", i_rst_r, 0);
        i_rd_v = 1; i_rd_sid = 0; o_addr_r = 1;
        cycle();
        chk("t3_ptr0_v", o_addr_v, 1);
        chk("t3_ptr0", o_addr_ptr, 10'h0FF);
        cycle();
        i_rd_v = 0;
        chk("t3_ptr1", o_addr_ptr, 10'h000);
        chk("t3_rst_r_idle", i_rst_r, 1);
        chk("t3_end_lag", o_end[0], 0);
        cycle();
        chk("t3_end", o_end[0], 1);
        load(0, 64'h2000, 64'h2100, 2);
        chk("t3_rereset_ea", o_req_ea, 64'h2000);
        chk("t3_end_clr_pending", o_req_v, 1);

        // Window clamp: 0 and 300 both allow 256 lines in flight.
        for (int t = 0; t < 2; t++) begin
            hard_reset();
            load(1, 64'h100000, 64'h200000, (t == 0) ? 0 : 300);
            o_req_r = 1; acc_ea.delete(); acc_sid.delete();
            repeat (300) cycle();
            chk("t4_nreq", 64'(acc_ea.size()), 256);
            chk("t4_stall", o_req_v, 0);
        end

        // Same-stream request, response and read in one cycle.
        hard_reset();
        load(0, 64'h1000, 64'h100000, 4);
        o_req_r = 1; repeat (2) cycle();
        o_req_r = 0; i_rsp_v = 1; i_rsp_sid = 0; cycle();
        o_req_r = 1; i_rd_v = 1; i_rd_sid = 0; o_addr_r = 1;
        acc_ea.delete(); acc_sid.delete();
        cycle();
        i_rsp_v = 0; i_rd_v = 0;
        chk("t5_ptr", o_addr_ptr, 10'h020);
        repeat (4) cycle();
        chk("t5_nreq", 64'(acc_ea.size()), 3);
        if (acc_ea.size() == 3) chk("t5_last_ea", acc_ea[2], 64'h1200);

        // Async reset in the middle of a busy burst.
        i_rsp_v = 1; i_rsp_sid = 0; i_rd_v = 1; i_rd_sid = 0; o_addr_r = 0;
        repeat (2) cycle();
        chk("t6_busy_addr_v", o_addr_v, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_req_v", o_req_v, 0);
        chk("t6_req_ea", o_req_ea, 0);
        chk("t6_req_sid", o_req_sid, 0);
        chk("t6_addr_v", o_addr_v, 0);
        chk("t6_addr_ptr", o_addr_ptr, 0);
        chk("t6_end", o_end, 0);
        chk("t6_rst_r", i_rst_r, 1);
        chk("t6_rd_r", i_rd_r, 0);
        chk("t6_rsp_r", i_rsp_r, 1);
        @(negedge clk);
        hard_reset();

        // Randomized traffic on all streams.
        for (int c = 0; c < 4000; c++) begin
            int s;
            idle_inputs();
            o_req_r   = ($urandom_range(0, 3) != 0);
            o_addr_r  = ($urandom_range(0, 3) != 0);
            i_rst_v   = ($urandom_range(0, 3) == 0);
            i_rst_sid = 2'($urandom_range(0, NS - 1));
            i_rst_ea_b = 64'($urandom_range(0, 32'h0FFF_FFFF)) | (64'($urandom_range(0, 255)) << 40);
            i_rst_ea_e = i_rst_ea_b + 64'($urandom_range(0, 1500));
            i_rst_win  = ($urandom_range(0, 9) == 0) ? 9'd300 : 9'($urandom_range(0, 9));
            i_rd_v    = ($urandom_range(0, 1) == 1);
            i_rd_sid  = 2'($urandom_range(0, NS - 1));
            s = int'($urandom_range(0, NS - 1));
            if (m_nout[s] > 0 && $urandom_range(0, 2) != 0) begin
                i_rsp_v = 1; i_rsp_sid = 2'(s);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
